// File: rtl/i2s_slave_transmitter_if.sv
// PCM sample strobes from the audio pipeline into the I2S slave transmitter.
interface i2s_slave_transmitter_if #(
  parameter int DATA_WIDTH = 24
);
  // Handshake: l_data/r_data are valid only in the cycle their *_en strobe is high.
  // There is no backpressure; a pair arriving while the FIFO is full is dropped and flagged.
  logic                  l_data_en;
  logic                  r_data_en;
  logic [DATA_WIDTH-1:0] l_data;
  logic [DATA_WIDTH-1:0] r_data;

  modport master (output l_data_en, r_data_en, l_data, r_data);
  modport slave  (input  l_data_en, r_data_en, l_data, r_data);
endinterface

// File: rtl/i2s_slave_transmitter.sv
// Slave-mode I2S transmitter following external bclk/lrclk, with an L/R pair FIFO.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: underrun frames repeat the last popped pair.
module i2s_slave_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  i2s_slave_transmitter_if.slave pcm,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  clear_status,
  output logic                  s_data,
  output logic                  underrun,
  output logic                  overrun,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [1:0]            state_dbg
);
  localparam int AW = LVL_W - 1;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LEFT       = 2'd1,
    RIGHT      = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            bclk_sync_q, bclk_sync_d;
  logic [1:0]            lr_sync_q, lr_sync_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] pend_l_q, pend_l_d;
  logic                  s_data_q, s_data_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LVL_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         mem_d [FIFO_DEPTH];
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [PW-1:0]         last_q, last_d;
`endif

  logic          bclk_fall, lr_now, lr_change, left_start, right_start;
  logic          fifo_empty, fifo_full, push, push_ok, pop;
  logic [PW-1:0] head;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], bclk};
    lr_sync_d   = {lr_sync_q[0], lrclk};
    bclk_fall   = bclk_sync_q[2] & ~bclk_sync_q[1];
    lr_now      = lr_sync_q[1];
    lr_change   = bclk_fall && (lr_now != lr_prev_q);
    left_start  = lr_change && !lr_now;
    right_start = lr_change && lr_now && (state_q == LEFT);
    lr_prev_d   = bclk_fall ? lr_now : lr_prev_q;

    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    push       = run && pcm.r_data_en;
    push_ok    = push && !fifo_full;
    pop        = run && left_start && !fifo_empty;
    head       = mem_q[rd_ptr_q[AW-1:0]];

    state_d  = state_q;
    sh_d     = sh_q;
    hold_r_d = hold_r_q;
    s_data_d = s_data_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    last_d   = last_q;
`endif
    pend_l_d = (run && pcm.l_data_en) ? pcm.l_data : pend_l_q;

    // A same-cycle left strobe bypasses the pending register.
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {(pcm.l_data_en ? pcm.l_data : pend_l_q), pcm.r_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

    overrun_d  = (overrun_q  & ~clear_status) | (push && fifo_full);
    underrun_d = (underrun_q & ~clear_status) | (run && left_start && fifo_empty);

    // The slot-start edge still emits the old MSB; the new word's MSB follows one bclk later.
    if (bclk_fall) begin
      s_data_d = sh_q[DATA_WIDTH-1];
      sh_d     = sh_q << 1;
    end
    if (left_start) begin
      state_d = LEFT;
      if (!fifo_empty) begin
        sh_d     = head[PW-1:DATA_WIDTH];
        hold_r_d = head[DATA_WIDTH-1:0];
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        last_d   = head;
`endif
      end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        sh_d     = last_q[PW-1:DATA_WIDTH];
        hold_r_d = last_q[DATA_WIDTH-1:0];
`else
        sh_d     = '0;
        hold_r_d = '0;
`endif
      end
    end else if (right_start) begin
      state_d = RIGHT;
      sh_d    = hold_r_q;
    end

    // Leaving run flushes everything except the sticky flags.
    if (!run) begin
      state_d  = WAIT_FRAME;
      sh_d     = '0;
      hold_r_d = '0;
      pend_l_d = '0;
      s_data_d = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_FRAME;
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      lr_prev_q   <= 1'b0;
      sh_q        <= '0;
      hold_r_q    <= '0;
      pend_l_q    <= '0;
      s_data_q    <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      lr_prev_q   <= lr_prev_d;
      sh_q        <= sh_d;
      hold_r_q    <= hold_r_d;
      pend_l_q    <= pend_l_d;
      s_data_q    <= s_data_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s_data     = s_data_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;
  assign fifo_level = level_q;
  assign state_dbg  = state_q;
endmodule

// File: doc/i2s_slave_transmitter.md
Name: i2s_slave_transmitter

Overview:
- Slave-mode I2S transmitter: serialises processed 24-bit L/R PCM back onto an I2S bus whose bclk/lrclk are driven externally (same bus pins that feed I2S_to_PCM_Converter), e.g. a capture/return path to the host.
- Accepts per-channel sample strobes from the audio pipeline (AudioMux output side) and buffers L/R pairs in a small FIFO.
- Shifts pairs out MSB-first, aligned to the external frame.
- Differs from PCM_to_I2S_Converter, which generates its own clocks; this block follows them.

Parameters:
- DATA_WIDTH, 24, PCM sample width.
- FIFO_DEPTH, 4, L/R pairs buffered; power of 2, ≥2.
- LVL_W, $clog2(FIFO_DEPTH)+1, fifo_level width.

Ports:
- clk  in  1  system clock; must be ≥8× bclk frequency.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  enable (audio_control[0]).
- l_data_en  in  1  strobe, l_data valid.
- r_data_en  in  1  strobe, r_data valid; completes a pair.
- l_data  in  DATA_WIDTH  left sample, two's complement.
- r_data  in  DATA_WIDTH  right sample.
- bclk  in  1  external bit clock, asynchronous.
- lrclk  in  1  external word clock, asynchronous; 0 = left.
- clear_status  in  1  pulse; clears sticky flags.
- s_data  out  1  serial data.
- underrun  out  1  sticky: frame started with FIFO empty.
- overrun  out  1  sticky: pair pushed while FIFO full.
- fifo_level  out  LVL_W  pairs currently stored.

Behaviour:
- Reset, run=0, and reset asserted mid-frame all produce the same state: s_data=0, underrun=0, overrun=0, fifo_level=0, FIFO flushed, shifter=0, pending-left=0, state=WAIT_FRAME. The one exception: run=0 does not clear the flags; only reset or clear_status does.
- Synchroniser: bclk and lrclk each pass through 2 FFs, then a third FF for edge detection. A bclk falling edge is detected 3 clk after the pin edge. lrclk is sampled only at detected bclk falling edges and compared with the value sampled at the previous falling edge.
- Input side:
  - l_data_en latches l_data into pending-left.
  - r_data_en pushes {pending-left, r_data} into the FIFO.
  - If both strobes occur in the same cycle, the pair pushed is {l_data, r_data}.
  - Push while full: pair dropped, overrun←1, FIFO contents unchanged.
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
- Shifter, at each detected bclk falling edge: s_data←sh[MSB], sh←sh<<1 with zero fill, register update 1 clk after detection. Bits beyond DATA_WIDTH in a slot are 0.
- Slot start is an lrclk change seen at a falling edge:
  - The current edge still outputs the old sh[MSB]. This is the LSB of the previous word when slot = 24 bclk, otherwise 0.
  - After that output, sh is loaded with the new word. Its MSB goes out on the next falling edge, giving the standard I2S 1-bit delay.
  - Valid for any slot width ≥ DATA_WIDTH.
- State machine:
  - WAIT_FRAME: s_data=0. Leave only on an lrclk 1→0 change (left slot start), go to LEFT; a 0→1 change is ignored.
  - LEFT: entered on 1→0. If FIFO non-empty: pop, load left word, hold right word. If empty: load 0, hold right word 0, underrun←1. On 0→1 change go to RIGHT.
  - RIGHT: load held right word. On 1→0 change go to LEFT.
  - run 1→0 in any state: go to WAIT_FRAME immediately.
- Flags: clear_status clears both flags. A set event in the same cycle as clear_status wins (flag = 1).
- fifo_level is a registered count, 0..FIFO_DEPTH, and wraps correctly with the pointers (extra MSB scheme).

Optional Feature:
- Macro: I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: an underrun frame retransmits the last successfully popped pair (0 if none since reset/run); the underrun flag still sets.
- Undefined: an underrun frame transmits zeros in both slots.

Test Plan:
- Basic: 32-bit slots (bclk = 64fs), push L=0xA5A5A5, R=0x123456, run=1 → left slot bits 1..24 = 0xA5A5A5 MSB-first, bits 25..31 = 0. Right slot = 0x123456. fifo_level goes 1→0 at left-slot start.
- 24-bit slots (bclk = 48fs), back-to-back pairs 0x800001 / 0x7FFFFF → LSB of the left word appears on the edge where lrclk rises; no bit is lost or duplicated.
- Overrun: push 5 pairs with run=1 before the first frame, FIFO_DEPTH=4 → overrun=1, fifo_level=4, 5th pair never transmitted. Then clear_status → overrun=0.
- Underrun: empty FIFO at a left-slot start → s_data=0 for the whole frame, underrun=1. With I2S_TX_REPEAT_ON_UNDERRUN_EN defined → previous pair repeated, underrun=1.
- Mid-frame start: run asserted while lrclk=1 (right slot) → s_data=0 until the next lrclk fall. The first pushed pair goes out in that frame with no pop before it.
- reset_n low mid-word → next clk: s_data=0, fifo_level=0, flags=0. After release, output stays 0 until an lrclk falling edge.
